uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a byte FIFO, enable gating and break generation
module uart_tx #(
   parameter int CLK_HZ         = 100000000,
   parameter int BIT_RATE       = 9600,
   parameter int CLOCKS_PER_BIT = CLK_HZ / BIT_RATE,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       uart_tx_en,
   input  logic       uart_tx_valid,
   input  logic [7:0] uart_tx_data,
   output logic       uart_tx_ready,
   input  logic       uart_tx_break,
   output logic       uart_txd,
   output logic       uart_tx_busy,
   output logic       uart_tx_done
);
   localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = AW + 1;
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [OW-1:0] FULL = OW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, BRK_MARK} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          push, pop, last, decide;

   assign uart_tx_ready = occ_q < FULL;
   assign uart_txd      = txd_q;
   assign uart_tx_busy  = state_q != IDLE;
   assign last          = cnt_q == LAST;
   assign uart_tx_done  = state_q == STOP && last;
   assign push          = uart_tx_valid && uart_tx_ready;
   // the last stop-bit cycle makes the same start/break choice as IDLE so frames run back to back
   assign decide        = state_q == IDLE || uart_tx_done;

   // FIFO pointers wrap naturally at the power-of-two depth
   always_comb begin
      wr_d  = push ? wr_q + AW'(1) : wr_q;
      rd_d  = pop ? rd_q + AW'(1) : rd_q;
      occ_d = occ_q + OW'(push) - OW'(pop);
   end

   // FSM next state, bit timing and registered line value
   always_comb begin
      state_d = state_q;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      case (state_q)
         START: if (last) begin
            state_d = DATA;
            idx_d   = '0;
            txd_d   = shift_q[0];
         end
         DATA: if (last) begin
            if (idx_q == 3'd7) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end else begin
               idx_d = idx_q + 3'd1;
               txd_d = shift_q[idx_q + 3'd1];
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (!uart_tx_break) begin
               state_d = BRK_MARK;
               txd_d   = 1'b1;
            end
         end
         BRK_MARK: if (last) begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
         default: ;
      endcase
      if (decide) begin
         cnt_d   = '0;
         state_d = IDLE;
         txd_d   = 1'b1;
         if (uart_tx_break) begin
            state_d = BREAK;
            txd_d   = 1'b0;
         end else if (uart_tx_en && occ_q != '0) begin
            state_d = START;
            txd_d   = 1'b0;
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
         end
      end
   end

   // state registers; reset abandons any frame and flushes the queue
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         wr_q    <= '0;
         rd_q    <= '0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
      end
   end

   // FIFO storage
   always_ff @(posedge CLK) begin
      if (push && !reset) mem_q[wr_q] <= uart_tx_data;
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed tests of uart_tx against a waveform-queue model plus literal expectations
module tb_uart_tx;
   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       uart_tx_en = 1'b0;
   logic       uart_tx_valid = 1'b0;
   logic [7:0] uart_tx_data = 8'h00;
   logic       uart_tx_break = 1'b0;
   logic       uart_tx_ready, uart_txd, uart_tx_busy, uart_tx_done;

   int errors = 0;
   int checks = 0;

   uart_tx #(.CLK_HZ(1000), .BIT_RATE(100), .FIFO_DEPTH(4)) dut (
      .CLK(CLK),
      .reset(reset),
      .uart_tx_en(uart_tx_en),
      .uart_tx_valid(uart_tx_valid),
      .uart_tx_data(uart_tx_data),
      .uart_tx_ready(uart_tx_ready),
      .uart_tx_break(uart_tx_break),
      .uart_txd(uart_txd),
      .uart_tx_busy(uart_tx_busy),
      .uart_tx_done(uart_tx_done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: queued bytes, and one {txd,done} entry per future cycle of the current frame or mark
   logic [7:0] mq[$];
   logic [1:0] wq[$];
   bit         m_brk = 1'b0;
   bit         armed = 1'b0;
   bit         m_rdy;
   logic [9:0] m_frame;
   logic [7:0] m_byte;

   always @(posedge CLK) begin
      if (reset) begin
         mq.delete();
         wq.delete();
         m_brk = 1'b0;
         armed = 1'b1;
      end else begin
         m_rdy = mq.size() < 4;
         if (wq.size() > 0) void'(wq.pop_front());
         if (m_brk) begin
            if (!uart_tx_break) begin
               m_brk = 1'b0;
               repeat (10) wq.push_back(2'b10);
            end
         end else if (wq.size() == 0) begin
            if (uart_tx_break) m_brk = 1'b1;
            else if (uart_tx_en && mq.size() > 0) begin
               m_byte  = mq.pop_front();
               m_frame = {1'b1, m_byte, 1'b0};
               for (int i = 0; i < 10; i++)
                  for (int j = 0; j < 10; j++)
                     wq.push_back({m_frame[i], 1'b0 | (i == 9 && j == 9)});
            end
         end
         if (uart_tx_valid && m_rdy) mq.push_back(uart_tx_data);
      end
   end

   always @(negedge CLK) begin
      if (armed) begin
         chk("txd", 32'(uart_txd), 32'(m_brk ? 1'b0 : (wq.size() > 0 ? wq[0][1] : 1'b1)));
         chk("busy", 32'(uart_tx_busy), 32'(m_brk || wq.size() > 0));
         chk("done", 32'(uart_tx_done), 32'(wq.size() > 0 && wq[0][0]));
         chk("ready", 32'(uart_tx_ready), 32'(mq.size() < 4));
      end
   end

   int busy_n, done_n, done_at, zero_n, first_busy;
   logic bits [10];
   logic [9:0] exp_bits;

   task automatic clr();
      busy_n = 0; done_n = 0; done_at = -1; zero_n = 0; first_busy = -1;
   endtask

   task automatic sample(input int k);
      busy_n += int'(uart_tx_busy);
      if (uart_tx_busy && first_busy < 0) first_busy = k;
      if (uart_tx_done) begin
         done_n++;
         done_at = k;
      end
      if (!uart_txd) zero_n++;
   endtask

   initial begin
      exp_bits = 10'b1101001010;
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      chk("rst_txd", 32'(uart_txd), 1);
      chk("rst_busy", 32'(uart_tx_busy), 0);
      chk("rst_done", 32'(uart_tx_done), 0);
      chk("rst_ready", 32'(uart_tx_ready), 1);

      // single byte 0xA5
      uart_tx_en = 1'b1; uart_tx_valid = 1'b1; uart_tx_data = 8'hA5;
      clr();
      for (int k = 0; k < 120; k++) begin
         @(negedge CLK);
         if (k == 0) uart_tx_valid = 1'b0;
         sample(k);
         if (k % 10 == 5 && k < 100) bits[k / 10] = uart_txd;
      end
      for (int i = 0; i < 10; i++) chk($sformatf("a5_bit%0d", i), 32'(bits[i]), 32'(exp_bits[i]));
      chk("a5_busy_cycles", busy_n, 100);
      chk("a5_done_count", done_n, 1);
      chk("a5_done_at", done_at, 100);

      // full queue with enable low, fifth write dropped
      uart_tx_en = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge CLK);
         if (i == 5) chk("full_ready_low", 32'(uart_tx_ready), 0);
         uart_tx_valid = 1'b1; uart_tx_data = 8'(i);
      end
      clr();
      for (int k = 0; k < 450; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            uart_tx_valid = 1'b0;
            uart_tx_en = 1'b1;
         end
         if (uart_tx_busy && first_busy < 0) chk("full_ready_after_pop", 32'(uart_tx_ready), 1);
         sample(k);
      end
      chk("full_first_busy", first_busy, 1);
      chk("full_busy_cycles", busy_n, 400);
      chk("full_done_count", done_n, 4);
      chk("full_last_done", done_at, 400);

      // enable dropped mid-frame
      uart_tx_en = 1'b0;
      @(negedge CLK); uart_tx_valid = 1'b1; uart_tx_data = 8'h3C;
      @(negedge CLK); uart_tx_data = 8'hC3;
      clr();
      for (int k = 0; k < 160; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            uart_tx_valid = 1'b0;
            uart_tx_en = 1'b1;
         end
         if (k == 30) uart_tx_en = 1'b0;
         sample(k);
      end
      chk("en_first_done", done_n, 1);
      chk("en_first_busy", busy_n, 100);
      chk("en_idle_txd", 32'(uart_txd), 1);
      clr();
      for (int k = 0; k < 110; k++) begin
         @(negedge CLK);
         if (k == 0) uart_tx_en = 1'b1;
         sample(k);
      end
      chk("en_second_done_at", done_at, 100);
      chk("en_second_busy", busy_n, 100);

      // break from idle
      clr();
      for (int k = 0; k < 80; k++) begin
         @(negedge CLK);
         if (k == 0) uart_tx_break = 1'b1;
         if (k == 50) uart_tx_break = 1'b0;
         sample(k);
      end
      chk("brk_zero_cycles", zero_n, 50);
      chk("brk_busy_cycles", busy_n, 60);
      chk("brk_no_done", done_n, 0);

      // break raised mid-frame waits for the frame to end
      uart_tx_en = 1'b0;
      @(negedge CLK); uart_tx_valid = 1'b1; uart_tx_data = 8'h55;
      clr();
      for (int k = 0; k < 160; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            uart_tx_valid = 1'b0;
            uart_tx_en = 1'b1;
         end
         if (k == 20) uart_tx_break = 1'b1;
         if (k == 130) uart_tx_break = 1'b0;
         sample(k);
      end
      chk("brkmid_done_at", done_at, 100);
      chk("brkmid_done_count", done_n, 1);
      chk("brkmid_zero_cycles", zero_n, 80);
      chk("brkmid_busy_cycles", busy_n, 140);

      // reset mid-frame with two bytes still queued, write during reset discarded
      uart_tx_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         uart_tx_valid = 1'b1; uart_tx_data = 8'h10 + 8'(i);
      end
      clr();
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            uart_tx_valid = 1'b0;
            uart_tx_en = 1'b1;
         end
         if (k == 45) begin
            reset = 1'b1;
            uart_tx_valid = 1'b1;
            uart_tx_data = 8'hFF;
         end
         if (k == 46) begin
            reset = 1'b0;
            uart_tx_valid = 1'b0;
            chk("rstmid_txd", 32'(uart_txd), 1);
            chk("rstmid_busy", 32'(uart_tx_busy), 0);
            chk("rstmid_ready", 32'(uart_tx_ready), 1);
         end
         sample(k);
      end
      chk("rstmid_busy_cycles", busy_n, 45);
      chk("rstmid_no_done", done_n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
